// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared types for the pipeline hazard/stall controller: FSM states,
// forwarding selects and the register-write descriptor used by forwarding.
package hazard_stall_ctrl_pkg;

  localparam int unsigned REG_W = 5;
  localparam int unsigned FWD_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_ERR  = 2'b10
  } state_t;

  typedef enum logic [FWD_W-1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_t;

  // Register-file write intent of a downstream stage
  typedef struct packed {
    logic [REG_W-1:0] rd;
    logic             we;
  } wr_port_t;

  // Pick the youngest in-flight producer of src; $0 never forwards
  function automatic fwd_t fwd_sel(input logic [REG_W-1:0] src,
                                   input wr_port_t         mem_wr,
                                   input wr_port_t         wb_wr);
    fwd_t sel;
    sel = FWD_RF;
    if (mem_wr.we && (mem_wr.rd != '0) && (mem_wr.rd == src)) begin
      sel = FWD_MEM;
    end else if (wb_wr.we && (wb_wr.rd != '0) && (wb_wr.rd == src)) begin
      sel = FWD_WB;
    end
    return sel;
  endfunction

endpackage

// File: rtl/hazard_stall_ctrl_fwd_unit.sv
// EX-stage operand forwarding selects for both ALU operands (combinational).
module hazard_stall_ctrl_fwd_unit
  import hazard_stall_ctrl_pkg::*;
(
  input  logic [REG_W-1:0] ex_rs,
  input  logic [REG_W-1:0] ex_rt,
  input  wr_port_t         mem_wr,
  input  wr_port_t         wb_wr,
  output fwd_t             fwd_a,
  output fwd_t             fwd_b
);

  // Same priority rule applied independently to each operand
  always_comb begin
    fwd_a = fwd_sel(ex_rs, mem_wr, wb_wr);
    fwd_b = fwd_sel(ex_rt, mem_wr, wb_wr);
  end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Stall/flush/forwarding controller for the 5-stage pipeline.
// Freeze (memory wait/timeout) > redirect > load-use. Control outputs are
// same-cycle decodes of the FSM state and inputs.
// Optional build macro HAZ_PERF_CNT_EN adds stall/flush event counters.
module hazard_stall_ctrl
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned TO_W        = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic [REG_W-1:0] ex_rs,
  input  logic [REG_W-1:0] ex_rt,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] mem_rd,
  input  logic             mem_reg_write,
  input  logic [REG_W-1:0] wb_rd,
  input  logic             wb_reg_write,
  input  logic             ex_redirect,
  input  logic             mem_access,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_write,
  output logic             idex_flush,
  output logic             exmem_write,
  output logic             memwb_flush,
  output logic [FWD_W-1:0] fwd_a,
  output logic [FWD_W-1:0] fwd_b,
  output logic             mem_err,
  output logic [1:0]       state
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [31:0]      stall_cycles,
  output logic [31:0]      flush_events
`endif
);

  state_t          state_q, state_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic            mem_err_q, mem_err_d;
  logic            freeze_c;
  logic            load_use_c;
  logic            redirect_act_c;
  logic            load_use_act_c;
  fwd_t            fwd_a_c, fwd_b_c;

  hazard_stall_ctrl_fwd_unit u_fwd (
    .ex_rs  (ex_rs),
    .ex_rt  (ex_rt),
    .mem_wr ('{rd: mem_rd, we: mem_reg_write}),
    .wb_wr  ('{rd: wb_rd, we: wb_reg_write}),
    .fwd_a  (fwd_a_c),
    .fwd_b  (fwd_b_c)
  );

  // FSM state, wait counter and sticky error flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mem_err_q <= mem_err_d;
    end
  end

  // Memory handshake sequencing: next state and freeze request
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mem_err_d = mem_err_q;
    freeze_c  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (mem_access && !mem_ready) begin
          state_d  = ST_WAIT;
          cnt_d    = TO_W'(1);
          freeze_c = 1'b1;
        end
      end
      ST_WAIT: begin
        if (mem_ready) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == TO_W'(MEM_TIMEOUT - 1)) begin
          state_d   = ST_ERR;
          mem_err_d = 1'b1;
          freeze_c  = 1'b1;
        end else begin
          cnt_d    = cnt_q + TO_W'(1);
          freeze_c = 1'b1;
        end
      end
      ST_ERR: begin
        mem_err_d = 1'b1;
        freeze_c  = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Load-use: loaded value is needed by the instruction right behind it
  always_comb begin
    load_use_c = ex_mem_read && (ex_rd != '0) &&
                 ((ex_rd == id_rs) || (ex_rd == id_rt));
    redirect_act_c = !freeze_c && ex_redirect;
    load_use_act_c = !freeze_c && !ex_redirect && load_use_c;
  end

  // Pipeline register enables/clears and forwarding selects
  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_write  = 1'b1;
    idex_flush  = 1'b0;
    exmem_write = 1'b1;
    memwb_flush = 1'b0;
    fwd_a       = fwd_a_c;
    fwd_b       = fwd_b_c;
    if (!rst) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_write  = 1'b0;
      exmem_write = 1'b0;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      memwb_flush = 1'b1;
      fwd_a       = FWD_RF;
      fwd_b       = FWD_RF;
    end else if (freeze_c) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_write  = 1'b0;
      exmem_write = 1'b0;
      memwb_flush = 1'b1;
    end else if (redirect_act_c) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (load_use_act_c) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      idex_flush = 1'b1;
    end
  end

  assign state   = state_q;
  assign mem_err = mem_err_q;

`ifdef HAZ_PERF_CNT_EN
  // Event counters, free-running modulo 2^32
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      if (freeze_c || load_use_act_c) begin
        stall_cycles <= stall_cycles + 32'd1;
      end
      if (redirect_act_c) begin
        flush_events <= flush_events + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed self-checking bench for hazard_stall_ctrl.
module tb_hazard_stall_ctrl;

  // {pc_write, ifid_write, ifid_flush, idex_write, idex_flush, exmem_write, memwb_flush}
  localparam logic [6:0] CTRL_RUN   = 7'b1101010;
  localparam logic [6:0] CTRL_RST   = 7'b0010101;
  localparam logic [6:0] CTRL_FRZ   = 7'b0000001;
  localparam logic [6:0] CTRL_REDIR = 7'b1111110;
  localparam logic [6:0] CTRL_LU    = 7'b0001110;

  logic       clk, rst;
  logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
  logic       ex_mem_read, mem_reg_write, wb_reg_write;
  logic       ex_redirect, mem_access, mem_ready;
  logic       pc_write, ifid_write, ifid_flush, idex_write, idex_flush;
  logic       exmem_write, memwb_flush, mem_err;
  logic [1:0] fwd_a, fwd_b, state;
`ifdef HAZ_PERF_CNT_EN
  logic [31:0] stall_cycles, flush_events;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  wire [6:0] ctrl = {pc_write, ifid_write, ifid_flush, idex_write,
                     idex_flush, exmem_write, memwb_flush};

  hazard_stall_ctrl #(.MEM_TIMEOUT(16), .TO_W(5)) dut (
    .clk          (clk),
    .rst          (rst),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .ex_rs        (ex_rs),
    .ex_rt        (ex_rt),
    .ex_rd        (ex_rd),
    .ex_mem_read  (ex_mem_read),
    .mem_rd       (mem_rd),
    .mem_reg_write(mem_reg_write),
    .wb_rd        (wb_rd),
    .wb_reg_write (wb_reg_write),
    .ex_redirect  (ex_redirect),
    .mem_access   (mem_access),
    .mem_ready    (mem_ready),
    .pc_write     (pc_write),
    .ifid_write   (ifid_write),
    .ifid_flush   (ifid_flush),
    .idex_write   (idex_write),
    .idex_flush   (idex_flush),
    .exmem_write  (exmem_write),
    .memwb_flush  (memwb_flush),
    .fwd_a        (fwd_a),
    .fwd_b        (fwd_b),
    .mem_err      (mem_err),
    .state        (state)
`ifdef HAZ_PERF_CNT_EN
    ,
    .stall_cycles (stall_cycles),
    .flush_events (flush_events)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Advance to just after the next rising edge; inputs are driven here
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    id_rs = '0; id_rt = '0; ex_rs = '0; ex_rt = '0; ex_rd = '0;
    mem_rd = '0; wb_rd = '0;
    ex_mem_read = 1'b0; mem_reg_write = 1'b0; wb_reg_write = 1'b0;
    ex_redirect = 1'b0; mem_access = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic rand_inputs();
    id_rs = 5'($urandom); id_rt = 5'($urandom); ex_rs = 5'($urandom);
    ex_rt = 5'($urandom); ex_rd = 5'($urandom); mem_rd = 5'($urandom);
    wb_rd = 5'($urandom);
    ex_mem_read = 1'($urandom); mem_reg_write = 1'($urandom);
    wb_reg_write = 1'($urandom); ex_redirect = 1'($urandom);
    mem_access = 1'b1; mem_ready = 1'b0;
  endtask

  initial begin
    clear_inputs();
    rst = 1'b0;

    // Reset held with random activity on the inputs
    for (int i = 0; i < 3; i++) begin
      rand_inputs();
      #1;
      check("rst_ctrl", 32'(ctrl), 32'(CTRL_RST));
      check("rst_fwd", 32'({fwd_a, fwd_b}), 32'd0);
      check("rst_state", 32'(state), 32'd0);
      check("rst_err", 32'(mem_err), 32'd0);
      tick();
    end
    clear_inputs();
    rst = 1'b1;
    #1;
    check("rel_state", 32'(state), 32'd0);
    check("rel_ctrl", 32'(ctrl), 32'(CTRL_RUN));

    // Load-use on rs, then the bubble, then on rt, then $0 and non-load cases
    tick();
    ex_mem_read = 1'b1; ex_rd = 5'd8; id_rs = 5'd8;
    #1 check("lu_rs", 32'(ctrl), 32'(CTRL_LU));
    tick();
    ex_mem_read = 1'b0; ex_rd = 5'd0; id_rs = 5'd9;
    #1 check("lu_bubble", 32'(ctrl), 32'(CTRL_RUN));
    tick();
    ex_mem_read = 1'b1; ex_rd = 5'd8; id_rs = 5'd3; id_rt = 5'd8;
    #1 check("lu_rt", 32'(ctrl), 32'(CTRL_LU));
    tick();
    ex_rd = 5'd0; id_rs = 5'd0; id_rt = 5'd0;
    #1 check("lu_r0", 32'(ctrl), 32'(CTRL_RUN));
    tick();
    ex_mem_read = 1'b0; ex_rd = 5'd8; id_rs = 5'd8;
    #1 check("lu_noload", 32'(ctrl), 32'(CTRL_RUN));
    tick();
    clear_inputs();

    // Forwarding priority and $0 exclusion
    mem_rd = 5'd5; mem_reg_write = 1'b1; wb_rd = 5'd5; wb_reg_write = 1'b1;
    ex_rs = 5'd5; ex_rt = 5'd6;
    #1 check("fwd_mem", 32'(fwd_a), 32'd2);
    check("fwd_b_none", 32'(fwd_b), 32'd0);
    mem_reg_write = 1'b0;
    #1 check("fwd_wb", 32'(fwd_a), 32'd1);
    mem_rd = 5'd0; wb_rd = 5'd0; mem_reg_write = 1'b1; ex_rt = 5'd0;
    #1 check("fwd_b_r0", 32'(fwd_b), 32'd0);
    mem_rd = 5'd7; ex_rt = 5'd7; wb_rd = 5'd7;
    #1 check("fwd_b_mem", 32'(fwd_b), 32'd2);
    tick();
    clear_inputs();

    // Memory wait: 3 frozen cycles then release in the ready cycle
    mem_access = 1'b1; mem_ready = 1'b0;
    mem_rd = 5'd5; mem_reg_write = 1'b1; ex_rs = 5'd5;
    #1 check("mw_frz0", 32'(ctrl), 32'(CTRL_FRZ));
    check("mw_fwd_frz", 32'(fwd_a), 32'd2);
    tick();
    #1 check("mw_state1", 32'(state), 32'd1);
    check("mw_frz1", 32'(ctrl), 32'(CTRL_FRZ));
    tick();
    #1 check("mw_frz2", 32'(ctrl), 32'(CTRL_FRZ));
    tick();
    mem_ready = 1'b1;
    #1 check("mw_ready_ctrl", 32'(ctrl), 32'(CTRL_RUN));
    check("mw_ready_state", 32'(state), 32'd1);
    tick();
    clear_inputs();
    #1 check("mw_idle", 32'(state), 32'd0);
    check("mw_after", 32'(ctrl), 32'(CTRL_RUN));

    // Redirect held through a freeze, acting on the release cycle
    tick();
    mem_access = 1'b1; ex_redirect = 1'b1;
    #1 check("rd_frz0", 32'(ctrl), 32'(CTRL_FRZ));
    tick();
    #1 check("rd_frz1", 32'(ctrl), 32'(CTRL_FRZ));
    tick();
    mem_ready = 1'b1;
    #1 check("rd_release", 32'(ctrl), 32'(CTRL_REDIR));
    tick();
    clear_inputs();
    ex_redirect = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd8; id_rs = 5'd8;
    #1 check("rd_over_lu", 32'(ctrl), 32'(CTRL_REDIR));
    tick();
    clear_inputs();

    // Timeout into the sticky error state, from a fresh reset
    #2 rst = 1'b0;
    #1 rst = 1'b1;
    mem_access = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      #1 check("to_frz", 32'(ctrl), 32'(CTRL_FRZ));
      check("to_state", 32'(state), (i == 0) ? 32'd0 : 32'd1);
      tick();
    end
    #1 check("to_err_state", 32'(state), 32'd2);
    check("to_err_flag", 32'(mem_err), 32'd1);
`ifdef HAZ_PERF_CNT_EN
    check("to_stall_cnt", stall_cycles, 32'd16);
`endif
    mem_access = 1'b0; mem_ready = 1'b1; ex_redirect = 1'b1;
    #1 check("err_frz", 32'(ctrl), 32'(CTRL_FRZ));
    tick();
    #1 check("err_sticky_state", 32'(state), 32'd2);
    check("err_sticky_flag", 32'(mem_err), 32'd1);

    // Asynchronous reset mid-cycle leaves ERR immediately
    #2 rst = 1'b0;
    #1 check("ar_state", 32'(state), 32'd0);
    check("ar_err", 32'(mem_err), 32'd0);
    check("ar_ctrl", 32'(ctrl), 32'(CTRL_RST));
`ifdef HAZ_PERF_CNT_EN
    check("ar_stall_cnt", stall_cycles, 32'd0);
    check("ar_flush_cnt", flush_events, 32'd0);
`endif
    clear_inputs();
    rst = 1'b1;
    #1 check("ar_run", 32'(ctrl), 32'(CTRL_RUN));
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
Central stall/flush/forwarding controller for the 5-stage MIPS pipeline.
- Drives write-enable and flush controls for the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
- Detects load-use hazards and selects EX-stage forwarding sources.
- Flushes on taken branch or jump resolved in EX.
- Sequences multi-cycle data-memory accesses with a ready handshake and timeout FSM.

Parameters:
MEM_TIMEOUT, 16, maximum wait cycles for mem_ready before the error state; must be ≥2.
TO_W, 5, width of the wait counter; must satisfy 2^TO_W > MEM_TIMEOUT.

Ports:
clk  in  1  clock, all state updates on posedge
rst  in  1  asynchronous, active-low reset
id_rs, id_rt  in  5  source registers of the instruction in ID
ex_rs, ex_rt  in  5  source registers of the instruction in EX
ex_rd  in  5  destination register in EX
ex_mem_read  in  1  EX instruction is a load
mem_rd  in  5  destination register in MEM
mem_reg_write  in  1  MEM instruction writes the register file
wb_rd  in  5  destination register in WB
wb_reg_write  in  1  WB instruction writes the register file
ex_redirect  in  1  taken branch or jump resolved in EX
mem_access  in  1  MEM stage holds a load or store
mem_ready  in  1  data memory completes the access this cycle
pc_write  out  1  PC update enable
ifid_write  out  1  IF/ID enable
ifid_flush  out  1  IF/ID clear
idex_write  out  1  ID/EX enable
idex_flush  out  1  ID/EX clear (bubble)
exmem_write  out  1  EX/MEM enable
memwb_flush  out  1  MEM/WB clear
fwd_a, fwd_b  out  2  EX operand select: 00 = register file, 01 = WB, 10 = MEM
mem_err  out  1  sticky memory timeout flag
state  out  2  FSM state: 00 IDLE, 01 WAIT, 10 ERR

Behaviour:
- FSM (registered) plus wait counter cnt[TO_W-1:0]. All control outputs are combinational decodes of state and inputs; no extra latency.
- rst low, asynchronous: state=IDLE, cnt=0, mem_err=0. While rst is low, force pc_write=ifid_write=idex_write=exmem_write=0, all flushes=1 and fwd=00.
- IDLE:
  - If mem_access=1 and mem_ready=0: enter WAIT, cnt=1, and freeze this cycle.
  - If mem_access=1 and mem_ready=1: zero-wait access, no freeze.
- WAIT:
  - Freeze every cycle.
  - If mem_ready=1: return to IDLE, cnt=0. Release takes effect this same cycle; no freeze is applied in that cycle.
  - If mem_ready=0 and cnt==MEM_TIMEOUT-1: enter ERR and set mem_err=1.
  - Otherwise cnt+1.
- ERR:
  - Permanent freeze; mem_err=1 until reset.
  - Ignores all inputs.
- Freeze:
  - pc_write=ifid_write=idex_write=exmem_write=0.
  - memwb_flush=1, so no duplicate writeback.
  - No other flush is asserted.
- Priority, highest first: freeze > redirect > load-use.
- Redirect (no freeze, ex_redirect=1): ifid_flush=1, idex_flush=1; all enables=1.
  - A redirect that arrives during a freeze is held in EX by the frozen registers and acts on the first unfrozen cycle.
- Load-use (no freeze, no redirect):
  - Condition: ex_mem_read=1, ex_rd≠0, and ex_rd equals id_rs or id_rt.
  - Response: pc_write=0, ifid_write=0, idex_flush=1, exmem_write=1.
  - Lasts exactly one cycle, because the bubble clears ex_mem_read.
- Default: all enables=1, all flushes=0.
- Forwarding (per operand; fwd_b identical using ex_rt):
  - fwd_a=10 if mem_reg_write, mem_rd≠0 and mem_rd==ex_rs.
  - Else fwd_a=01 if wb_reg_write, wb_rd≠0 and wb_rd==ex_rs.
  - Else fwd_a=00.
  - MEM beats WB when both match.
  - Forwarding is computed even during freeze.
- Register $0 never triggers a hazard or forwarding.

Optional Feature:
HAZ_PERF_CNT_EN: when defined, adds output ports stall_cycles[31:0] and flush_events[31:0], both cleared by rst.
- stall_cycles increments on each freeze or load-use cycle.
- flush_events increments on each redirect cycle.
- Both wrap modulo 2^32.

When undefined, neither port nor counter logic exists, and behaviour is otherwise identical.

Decomposition:
- Shared package holds:
  - state encodings (ST_IDLE=2'b00, ST_WAIT=2'b01, ST_ERR=2'b10);
  - forwarding encodings (FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10).
- One sub-module, fwd_unit: purely combinational; instantiated once and produces both fwd_a and fwd_b.
- FSM and hazard decode stay in the top module.

Test Plan:
1. Reset: hold rst=0 with random inputs → enables=0, flushes=1, state=00, mem_err=0. Release → state=00, enables=1.
2. Load-use: ex_mem_read=1, ex_rd=8, id_rs=8 → one cycle with pc_write=0, ifid_write=0, idex_flush=1. With ex_rd=0 → no stall.
3. Forwarding: mem_rd=wb_rd=5 (both writing), ex_rs=5 → fwd_a=10. With mem_reg_write=0 → fwd_a=01. ex_rt=0 with matching rd=0 → fwd_b=00.
4. Memory wait: mem_access=1 with mem_ready low for 3 cycles, then high → freeze for exactly 3 cycles with memwb_flush=1, return to IDLE, full flow in the ready cycle.
5. Simultaneous events: ex_redirect=1 during WAIT → no flush while frozen. On the cycle mem_ready=1, ifid_flush=idex_flush=1. Load-use coincident with redirect → redirect wins (pc_write=1).
6. Timeout: MEM_TIMEOUT=16, mem_ready held 0 → ERR after 16 frozen cycles, mem_err=1 and sticky. Async rst pulse mid-ERR → IDLE immediately. With HAZ_PERF_CNT_EN, stall_cycles=16 before the reset and 0 after it.
